// File: rtl/fp16_pkg.sv
// Shared FP16 types and helpers used by the ReLU, PE and pooling datapaths.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_PINF = 16'h7C00;

  // Any value with the sign bit set (including -0 and negative NaN) maps to +0.
  function automatic fp16_t fp16_sanitise_pos(input fp16_t x);
    return x[15] ? FP16_ZERO : x;
  endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational maximum of two sanitised (sign-clear) FP16 values.
module fp16_max2
  import fp16_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t y
);

  // With the sign bit clear, FP16 ordering matches unsigned integer ordering,
  // and any NaN pattern sits above +Inf so it wins the compare.
  assign y = (a > b) ? a : b;

endmodule

// File: rtl/maxpool2x2_fp16.sv
// Streaming 2x2 / stride-2 FP16 max-pool with a half-row line buffer.
module maxpool2x2_fp16
  import fp16_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last
);

  localparam int HALF = IMG_W / 2;
  localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int KW   = CW - 1;
  localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [KW-1:0] k;
  fp16_t         h_reg;
  fp16_t         x;
  fp16_t         pair_max;
  fp16_t         win_max;
  fp16_t         lbuf [HALF];
  logic          accept;
  logic          last_col;
  logic          last_row;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign x        = fp16_sanitise_pos(fp16_t'(in_data));
  assign k        = col[CW-1:1];
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));

  fp16_max2 u_pair_max (
    .a (h_reg),
    .b (x),
    .y (pair_max)
  );

  fp16_max2 u_win_max (
    .a (lbuf[k]),
    .b (pair_max),
    .y (win_max)
  );

  // Control, horizontal holding register and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      h_reg     <= FP16_ZERO;
      out_valid <= 1'b0;
      out_data  <= FP16_ZERO;
      out_last  <= 1'b0;
    end else if (clear) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          h_reg <= x;
        end else if (row[0]) begin
          out_data  <= win_max;
          out_valid <= 1'b1;
          out_last  <= last_row && last_col;
        end
      end
    end
  end

  // Line buffer carries no reset: the even-row pass rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (accept && !clear && !row[0] && col[0]) begin
      lbuf[k] <= pair_max;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_fp16.sv
// Directed bench for maxpool2x2_fp16 on an 8x8 frame.
module tb_maxpool2x2_fp16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  maxpool2x2_fp16 #(.IMG_W(8), .IMG_H(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  logic [15:0] q_d[$];
  logic        q_l[$];
  logic [15:0] exp_d[$];
  logic [15:0] frm[64];
  bit          rand_on = 1'b0;
  bit          drv_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are stable at the falling edge, so handshakes are observed there.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        q_d.push_back(out_data);
        q_l.push_back(out_last);
      end
      if (in_valid && in_ready) acc_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_on) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input logic [15:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("push_timeout", 32'(t), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_outs(input string tag, input int n);
    int t = 0;
    while (q_d.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    idle(3);
    check(tag, 32'(q_d.size()), 32'(n));
  endtask

  task automatic send_ramp();
    for (int n = 0; n < 64; n++) push(16'h3C00 + 16'(n));
  endtask

  task automatic check_ramp(input string tag);
    wait_outs({tag, "_cnt"}, 16);
    for (int m = 0; m < 16 && m < q_d.size(); m++) begin
      check({tag, "_data"}, 32'(q_d[m]), 32'(16'h3C00 + 16 * (m / 4) + 2 * (m % 4) + 9));
      check({tag, "_last"}, 32'(q_l[m]), 32'(m == 15));
    end
  endtask

  task automatic send_frame();
    for (int n = 0; n < 64; n++) push(frm[n]);
  endtask

  // Reference: direct 2x2 maximum over the stored frame, negatives as +0.
  task automatic model_frame();
    logic [15:0] mx, v;
    for (int wr = 0; wr < 4; wr++) begin
      for (int wc = 0; wc < 4; wc++) begin
        mx = 16'h0000;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            v = frm[(2 * wr + dr) * 8 + 2 * wc + dc];
            if (v[15]) v = 16'h0000;
            if (v > mx) mx = v;
          end
        end
        exp_d.push_back(mx);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Ramp frame with a free-running sink.
    send_ramp();
    check_ramp("ramp");
    q_d.delete(); q_l.delete();

    // Sign sanitising and NaN propagation.
    for (int n = 0; n < 64; n++) frm[n] = 16'h0000;
    frm[0] = 16'hC000; frm[1] = 16'h8000; frm[8] = 16'hBC00; frm[9] = 16'h0000;
    frm[2] = 16'h3C00; frm[3] = 16'h7C00; frm[10] = 16'h7E00; frm[11] = 16'h4000;
    send_frame();
    wait_outs("san_cnt", 16);
    check("san_neg_window", 32'(q_d[0]), 32'h0000);
    check("san_nan_window", 32'(q_d[1]), 32'h7E00);
    check("san_last", 32'(q_l[15]), 32'(1));
    check("san_not_last", 32'(q_l[14]), 32'(0));
    q_d.delete(); q_l.delete();

    // Backpressure on the first result.
    out_ready = 1'b0;
    acc_cnt   = 0;
    drv_done  = 1'b0;
    fork
      begin
        send_ramp();
        drv_done = 1'b1;
      end
    join_none
    begin
      int t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      #1;
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_first_data", 32'(out_data), 32'h3C09);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_accepted", 32'(acc_cnt), 32'(10));
      repeat (3) @(negedge clk);
      #1;
      check("bp_hold_data", 32'(out_data), 32'h3C09);
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check("bp_hold_accepted", 32'(acc_cnt), 32'(10));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_ramp("bp");
    begin
      int t = 0;
      while (!drv_done && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("bp_driver_done", 32'(drv_done), 32'(1));
    end
    q_d.delete(); q_l.delete();

    // Abort a partial frame, then a clean constant frame.
    for (int n = 0; n < 11; n++) push(16'h7BFF);
    idle(3);
    q_d.delete(); q_l.delete();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int n = 0; n < 64; n++) push(16'h4000);
    wait_outs("clr_cnt", 16);
    for (int m = 0; m < 16 && m < q_d.size(); m++) begin
      check("clr_data", 32'(q_d[m]), 32'h4000);
      check("clr_last", 32'(q_l[m]), 32'(m == 15));
    end
    q_d.delete(); q_l.delete();

    // Two back-to-back random frames, random gaps and random sink stalls.
    exp_d.delete();
    rand_on = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 64; n++) frm[n] = 16'($urandom);
      model_frame();
      for (int n = 0; n < 64; n++) begin
        idle($urandom_range(0, 2));
        push(frm[n]);
      end
    end
    rand_on = 1'b0;
    idle(1);
    out_ready = 1'b1;
    wait_outs("rnd_cnt", 32);
    for (int m = 0; m < 32 && m < q_d.size(); m++) begin
      check("rnd_data", 32'(q_d[m]), 32'(exp_d[m]));
      check("rnd_last", 32'(q_l[m]), 32'((m % 16) == 15));
    end
    q_d.delete(); q_l.delete();

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) push(16'h3C00 + 16'(n));
    check("ar_pre_valid", 32'(out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'(0));
    check("ar_out_data", 32'(out_data), 32'(0));
    check("ar_out_last", 32'(out_last), 32'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(1);
    q_d.delete(); q_l.delete();
    send_ramp();
    check_ramp("ar");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_fp16.md
Name: maxpool2x2_fp16

Overview:
- Streaming 2x2 / stride-2 max-pool stage that sits directly downstream of the FP16 ReLU at the systolic-array output drain.
- Consumes post-activation FP16 pixels in row-major order for an IMG_W x IMG_H feature map.
- Emits one FP16 maximum per 2x2 window, plus a frame-end marker, toward the output buffer.
- Uses a half-row line buffer, so each input pixel is read exactly once.

Parameters:
- IMG_W, 8, input row length in pixels; even, >=2.
- IMG_H, 8, input rows per frame; even, >=2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous frame abort; returns counters to frame start
- in_valid  input  1  input pixel valid
- in_ready  output  1  block can accept a pixel this cycle
- in_data  input  16  FP16 pixel
- out_valid  output  1  pooled result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  16  FP16 window maximum
- out_last  output  1  asserted with the final pooled result of a frame

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=16'h0000, out_last=0.
  - col=0, row=0, h_reg=0.
  - Line buffer contents are don't-care; the even-row pass always rewrites them before use.
- Beat accept: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready, which is a combinational function of registered state and out_ready.
- Output register handshake:
  - Holds its value while out_valid && !out_ready.
  - Clears out_valid on out_ready when no new result is loaded that cycle.
- Sanitise each pixel: x = in_data[15] ? 16'h0000 : in_data. Negative values and -0 become +0.
- Max compare: 16-bit unsigned compare of sanitised values. For non-negative FP16 this is correct ordering, and NaN (0x7C01..0x7FFF) beats +Inf, so NaN propagates.
- Counters:
  - col counts 0..IMG_W-1 and wraps to 0; row increments on col wrap.
  - row counts 0..IMG_H-1 and wraps to 0 at frame end.
- Per accepted beat, with k = col>>1:
  - Even row, even col: h_reg <= x.
  - Even row, odd col: lbuf[k] <= max(h_reg, x).
  - Odd row, even col: h_reg <= x.
  - Odd row, odd col: out_data <= max(lbuf[k], max(h_reg, x)); out_valid <= 1; out_last <= (row==IMG_H-1 && col==IMG_W-1).
- Latency: the result is valid on the cycle after the bottom-right pixel of its window is accepted.
- Throughput: one pixel per cycle sustained; IMG_W*IMG_H/4 outputs per frame.
- Backpressure: while out_valid && !out_ready, in_ready=0 and no state advances. This also stalls even-row beats, which is a simple, decided rule.
- Simultaneous release and new result: if out_ready is high while a new result is loaded, the old result is consumed and the new one is loaded in the same cycle; no bubble.
- clear:
  - Sets col=0, row=0, out_valid=0, out_last=0.
  - Takes priority over an input beat in the same cycle; that beat is accepted and discarded.
- Reset mid-frame: all partial windows are lost; the next accepted pixel is (row 0, col 0).
- Frame wrap: after the last pixel, the next pixel is row 0 of a new frame with no idle cycle.

Decomposition:
- Shared package fp16_pkg:
  - typedef fp16_t (16-bit).
  - FP16_ZERO=16'h0000, FP16_PINF=16'h7C00.
  - Function fp16_sanitise_pos.
  - Same package the ReLU and PE code use.
- Sub-module fp16_max2: combinational two-input maximum of sanitised non-negative FP16. Instantiated twice, for the even-row pair and the final 3-input reduction.
- Line buffer: inferred register array of IMG_W/2 x 16 inside the top module.

Test Plan:
- Stream 8x8 ramp in_data = 16'h3C00 + n (n=0..63), out_ready=1 -> 16 outputs.
  - Output m = 16'h3C00 + 16*(m/4) + 2*(m%4) + 9.
  - out_last only on the 16th output (16'h3C3F).
- Window with pixels {16'hC000, 16'h8000, 16'hBC00, 16'h0000} -> out_data=16'h0000. Window {16'h3C00, 16'h7C00, 16'h7E00, 16'h4000} -> 16'h7E00 (NaN propagated).
- Hold out_ready=0 after the first result (16'h3C09) -> in_ready=0 next cycle, out_data stable, no pixels consumed. Release -> stream resumes with no lost or duplicated outputs.
- Assert clear after 11 pixels, then stream a full frame of 16'h4000 -> exactly 16 outputs of 16'h4000 with a correct out_last. No stale partial window is emitted.
- Two back-to-back frames with random in_valid gaps and random out_ready -> output sequence matches the software reference model, and out_last appears every 16 outputs.
- rst_n low mid-frame while out_valid=1 -> out_valid, out_last and out_data drop to 0 asynchronously. The next frame pools correctly from pixel 0.
